// File: rtl/jamma_pkg.sv
// jamma_pkg: shared scan states and JAMMA joystick bit map for the input scanner.
package jamma_pkg;
    typedef enum logic [1:0] {SETTLE_P1, SAMPLE_P1, SETTLE_P2, SAMPLE_P2} scan_state_t;
    localparam int JOY_UP    = 0;
    localparam int JOY_DOWN  = 1;
    localparam int JOY_LEFT  = 2;
    localparam int JOY_RIGHT = 3;
    localparam int JOY_FIRE  = 4;
    localparam int JOY_START = 7;
    localparam logic [7:0] JOY_IDLE = 8'hFF;
endpackage

// File: rtl/jamma_debounce.sv
// jamma_debounce: single-bit debouncer, output follows raw after DEBOUNCE_SAMPLES consecutive differing samples.
module jamma_debounce #(
    parameter int DEBOUNCE_SAMPLES = 3
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic sample_en,
    input  logic raw,
    output logic q
);
    localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            q   <= 1'b1;
            cnt <= '0;
        end else if (sample_en) begin
            if (raw == q) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_SAMPLES - 1)) begin
                q   <= raw;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/jamma_joy_scanner.sv
// jamma_joy_scanner: multiplexes the shared JAMMA joystick bus between players,
// debounces both player words and debounces/stretches the coin inputs.
module jamma_joy_scanner
    import jamma_pkg::*;
#(
    parameter int SETTLE_CYCLES    = 4,
    parameter int DEBOUNCE_SAMPLES = 3,
    parameter int COIN_STRETCH     = 16
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce,
    input  logic [7:0] jjoy,
    input  logic [5:0] joy_local,
    input  logic [1:0] jcoin,
    output logic       jselect,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic [1:0] coin,
    output logic       scan_done
);
    localparam int SW  = $clog2(SETTLE_CYCLES + 1);
    localparam int CSW = $clog2(COIN_STRETCH + 1);

    scan_state_t   state, state_nx;
    logic [SW-1:0] settle_cnt, settle_cnt_nx;
    logic          settle_done, sample1, sample2;
    logic [7:0]    raw1;
    logic [1:0]    coin_db;

    always_comb begin
        settle_done   = settle_cnt == SW'(SETTLE_CYCLES - 1);
        state_nx      = state;
        settle_cnt_nx = settle_cnt;
        case (state)
            SETTLE_P1: begin
                state_nx      = settle_done ? SAMPLE_P1 : SETTLE_P1;
                settle_cnt_nx = settle_done ? '0 : settle_cnt + 1'b1;
            end
            SAMPLE_P1: state_nx = SETTLE_P2;
            SETTLE_P2: begin
                state_nx      = settle_done ? SAMPLE_P2 : SETTLE_P2;
                settle_cnt_nx = settle_done ? '0 : settle_cnt + 1'b1;
            end
            default:   state_nx = SETTLE_P1;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= SETTLE_P1;
            settle_cnt <= '0;
            jselect    <= 1'b0;
        end else if (ce) begin
            state      <= state_nx;
            settle_cnt <= settle_cnt_nx;
            jselect    <= state_nx == SETTLE_P2 || state_nx == SAMPLE_P2;
        end
    end

    assign sample1   = ce && state == SAMPLE_P1;
    assign sample2   = ce && state == SAMPLE_P2;
    assign scan_done = sample2;
    assign raw1      = jjoy & {2'b11, joy_local};

    for (genvar i = 0; i < 8; i++) begin : g_joy
        jamma_debounce #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_db1 (
            .clk_sys(clk_sys), .reset(reset), .sample_en(sample1), .raw(raw1[i]), .q(joy1[i])
        );
        jamma_debounce #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_db2 (
            .clk_sys(clk_sys), .reset(reset), .sample_en(sample2), .raw(jjoy[i]), .q(joy2[i])
        );
    end

    for (genvar i = 0; i < 2; i++) begin : g_coin
        logic           db_q;
        logic [CSW-1:0] stretch;
        jamma_debounce #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_dbc (
            .clk_sys(clk_sys), .reset(reset), .sample_en(sample1), .raw(jcoin[i]), .q(coin_db[i])
        );
        // the press edge is seen on the ce tick after the debouncer falls; coin is already low via coin_db
        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                db_q    <= 1'b1;
                stretch <= '0;
            end else if (ce) begin
                db_q    <= coin_db[i];
                stretch <= (db_q && !coin_db[i]) ? CSW'(COIN_STRETCH)
                         : (scan_done && stretch != '0) ? stretch - 1'b1 : stretch;
            end
        end
        assign coin[i] = coin_db[i] && stretch == '0;
    end
endmodule

// File: tb/tb_jamma_joy_scanner.sv
// tb_jamma_joy_scanner: directed scans with a scoreboard checked one cycle after each scan_done.
module tb_jamma_joy_scanner;
    import jamma_pkg::*;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0;
    logic [7:0] p1_bus = JOY_IDLE;
    logic [7:0] p2_bus = JOY_IDLE;
    logic [5:0] joy_local = 6'h3F;
    logic [1:0] jcoin = 2'b11;
    logic [7:0] jjoy;
    logic       jselect, scan_done;
    logic [7:0] joy1, joy2;
    logic [1:0] coin;

    int          tests = 0;
    int          fails = 0;
    int          scan_no = 0;
    logic [17:0] exp_q[$];

    assign jjoy = jselect ? p2_bus : p1_bus;

    jamma_joy_scanner dut (
        .clk_sys(clk_sys), .reset(reset), .ce(ce), .jjoy(jjoy), .joy_local(joy_local),
        .jcoin(jcoin), .jselect(jselect), .joy1(joy1), .joy2(joy2), .coin(coin),
        .scan_done(scan_done)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_scan(input logic [7:0] j1, input logic [7:0] j2, input logic [1:0] c);
        exp_q.push_back({j1, j2, c});
    endtask

    task automatic wait_scan();
        int n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!scan_done && n < 100);
        if (!scan_done) begin
            tests++;
            fails++;
            $display("FAIL scan_timeout: got no scan_done expected one within 100 cycles");
        end
        @(posedge clk_sys);
        #1;
    endtask

    task automatic run_scan(input logic [7:0] p1, input logic [7:0] p2, input logic [5:0] loc,
                            input logic [1:0] jc, input logic [7:0] ej1, input logic [7:0] ej2,
                            input logic [1:0] ec);
        p1_bus    = p1;
        p2_bus    = p2;
        joy_local = loc;
        jcoin     = jc;
        expect_scan(ej1, ej2, ec);
        wait_scan();
    endtask

    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk_sys);
            if (scan_done) begin
                @(negedge clk_sys);
                scan_no++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scan%0d_unexpected: got scan_done expected none", scan_no);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("scan%0d_joy1", scan_no), 32'(joy1), 32'(e[17:10]));
                    chk($sformatf("scan%0d_joy2", scan_no), 32'(joy2), 32'(e[9:2]));
                    chk($sformatf("scan%0d_coin", scan_no), 32'(coin), 32'(e[1:0]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk_sys);
        chk("rst_joy1", 32'(joy1), 32'hFF);
        chk("rst_joy2", 32'(joy2), 32'hFF);
        chk("rst_coin", 32'(coin), 32'h3);
        chk("rst_jselect", 32'(jselect), 32'h0);
        chk("rst_scan_done", 32'(scan_done), 32'h0);

        ce = 1'b1;
        expect_scan(8'hFF, 8'hFF, 2'b11);
        expect_scan(8'hFF, 8'hFF, 2'b11);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            n = i + 1;
            chk($sformatf("period_jselect_%0d", n), 32'(jselect), 32'((n / 5) % 2));
            chk($sformatf("period_scan_done_%0d", n), 32'(scan_done), 32'(n % 10 == 9));
        end

        // player 1 up only while jselect=0, then DB9 down replaces it
        for (int s = 0; s < 3; s++) run_scan(8'hFE, 8'hFF, 6'h3F, 2'b11, s == 2 ? 8'hFE : 8'hFF, 8'hFF, 2'b11);
        for (int s = 0; s < 3; s++) run_scan(8'hFF, 8'hFF, 6'h3D, 2'b11, s == 2 ? 8'hFD : 8'hFE, 8'hFF, 2'b11);
        // two-sample fire glitches on player 2, twice, must never reach joy2
        run_scan(8'hFF, 8'hEF, 6'h3F, 2'b11, 8'hFD, 8'hFF, 2'b11);
        run_scan(8'hFF, 8'hEF, 6'h3F, 2'b11, 8'hFD, 8'hFF, 2'b11);
        run_scan(8'hFF, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);
        run_scan(8'hFF, 8'hEF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);
        run_scan(8'hFF, 8'hEF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);
        run_scan(8'hFF, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);
        // coin 0 held 3 scans with player 2 start, then stretched
        for (int s = 0; s < 3; s++) run_scan(8'hFF, 8'h7F, 6'h3F, 2'b10, 8'hFF, s == 2 ? 8'h7F : 8'hFF, s == 2 ? 2'b10 : 2'b11);
        run_scan(8'hFF, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'h7F, 2'b10);
        run_scan(8'hFF, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'h7F, 2'b10);
        run_scan(8'hFF, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b10);
        run_scan(8'hFF, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b10);
        run_scan(8'hFF, 8'hFF, 6'h3F, 2'b01, 8'hFF, 8'hFF, 2'b10);
        for (int s = 23; s <= 33; s++) run_scan(8'hFF, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'hFF, s >= 32 ? 2'b11 : 2'b10);
        for (int s = 0; s < 3; s++) run_scan(8'hFE, 8'hFF, 6'h3F, 2'b11, s == 2 ? 8'hFE : 8'hFF, 8'hFF, 2'b11);

        // reset in the middle of SETTLE_P2 while joy1 is pressed
        n = 0;
        while (!jselect && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        chk("mid_p2_reached", 32'(jselect), 32'h1);
        @(negedge clk_sys);
        reset = 1'b1;
        ce    = 1'b0;
        #1;
        chk("arst_joy1", 32'(joy1), 32'hFF);
        chk("arst_joy2", 32'(joy2), 32'hFF);
        chk("arst_coin", 32'(coin), 32'h3);
        chk("arst_jselect", 32'(jselect), 32'h0);
        chk("arst_scan_done", 32'(scan_done), 32'h0);
        @(negedge clk_sys);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            chk($sformatf("ce_low_jselect_%0d", i), 32'(jselect), 32'h0);
            chk($sformatf("ce_low_scan_done_%0d", i), 32'(scan_done), 32'h0);
        end
        expect_scan(8'hFF, 8'hFF, 2'b11);
        ce = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk_sys);
            chk($sformatf("first_sample_jselect_%0d", i), 32'(jselect), 32'(i == 5));
        end
        wait_scan();
        run_scan(8'hFE, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);
        run_scan(8'hFE, 8'hFF, 6'h3F, 2'b11, 8'hFE, 8'hFF, 2'b11);

        repeat (3) @(negedge clk_sys);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/jamma_joy_scanner.md
Name: jamma_joy_scanner

Overview:
- Time-multiplexes the shared 8-bit JAMMA joystick bus (JJOY) between player 1 and player 2 by driving JSELECT.
- Waits a settle window after each select change, then samples, debounces per bit and presents stable active-low player words to the game core.
- Also debounces and pulse-stretches the two coin inputs so short coin-mech pulses are never missed by the core.
- Sits in each arcade top between the JAMMA pins and the CTR1/CTR2 input assembly.

Parameters:
- SETTLE_CYCLES, 4, ce ticks after a JSELECT change before sampling; legal range 1..255.
- DEBOUNCE_SAMPLES, 3, consecutive identical samples required before an output bit changes; legal range 1..15.
- COIN_STRETCH, 16, minimum number of completed scans for which a coin output stays asserted.

Ports:
- clk_sys  in  1  system clock (24 MHz).
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; all state advances only when ce=1.
- jjoy  in  8  shared JAMMA bus, active low: [0]up [1]down [2]left [3]right [4]fire [7]start.
- joy_local  in  6  DB9 joystick, active low; ANDed into player 1 bits [5:0] only.
- jcoin  in  2  coin switches, active low, unmultiplexed.
- jselect  out  1  bus select: 0 = player 1, 1 = player 2.
- joy1  out  8  debounced player 1 word, active low.
- joy2  out  8  debounced player 2 word, active low.
- coin  out  2  debounced, stretched coin outputs, active low.
- scan_done  out  1  one-clk_sys pulse when a P2 sample completes a scan.

Behaviour:
- Reset values: jselect=0, joy1=8'hFF, joy2=8'hFF, coin=2'b11, scan_done=0, FSM state=SETTLE_P1, all counters 0.
- FSM states: SETTLE_P1, SAMPLE_P1, SETTLE_P2, SAMPLE_P2.
  - SETTLE_P1: jselect=0. Counts ce ticks; after SETTLE_CYCLES ticks, go to SAMPLE_P1.
  - SAMPLE_P1: on one ce tick, sample raw1 = jjoy & {2'b11, joy_local} and sample jcoin. Go to SETTLE_P2.
  - SETTLE_P2: jselect=1 (registered, changes on entry). Same counting as SETTLE_P1. Go to SAMPLE_P2.
  - SAMPLE_P2: on one ce tick, sample raw2 = jjoy and assert scan_done for that clk_sys cycle. Go to SETTLE_P1.
- Scan period: 2*(SETTLE_CYCLES+1) ce ticks (10 with defaults). jselect is a square wave with this period.
- Bus changes during SETTLE states are ignored; only the SAMPLE tick is used.
- Debounce, applied independently per bit for joy1[7:0], joy2[7:0] and coin debounce:
  - Each bit has a counter of width clog2(DEBOUNCE_SAMPLES+1).
  - On a sample, if raw == current output, the counter clears.
  - Otherwise the counter increments; when it reaches DEBOUNCE_SAMPLES, the output bit takes the raw value and the counter clears.
  - Latency from a stable change to the output is DEBOUNCE_SAMPLES scans.
  - A glitch shorter than DEBOUNCE_SAMPLES samples never reaches the output.
  - Simultaneous changes on different bits are independent.
- Coin stretch, per coin:
  - On a debounced 1→0 transition, coin[i]=0 and a stretch counter loads COIN_STRETCH.
  - The counter decrements once per scan_done.
  - coin[i] returns to 1 only when the counter is 0 and the debounced coin is 1.
  - A new press while the counter is nonzero reloads it.
- ce=0: FSM, counters and outputs all hold. scan_done is never asserted while ce=0.
- Asynchronous reset at any point, including mid-scan, returns everything to the reset values. The next scan starts with SETTLE_P1.
- Counter widths are clog2-based; counters neither wrap nor overflow within the legal parameter ranges.

Decomposition:
- Shared package jamma_pkg:
  - FSM state typedef (2 bits).
  - Bit-index constants: JOY_UP=0, JOY_DOWN=1, JOY_LEFT=2, JOY_RIGHT=3, JOY_FIRE=4, JOY_START=7.
  - Idle constant JOY_IDLE=8'hFF.
- One sub-module, jamma_debounce: a single-bit debouncer with parameter DEBOUNCE_SAMPLES, ports clk_sys, reset, sample_en, raw, q (reset value 1). The scanner instantiates 18 of them.

Test Plan:
- Reset release with ce tied to 1 and defaults:
  - jselect toggles every 5 clk_sys cycles.
  - scan_done pulses every 10 cycles.
  - Outputs remain 8'hFF, 8'hFF, 2'b11.
- Present jjoy=8'hFE only while jselect=0, held for 3 scans:
  - joy1 becomes 8'hFE after the 3rd SAMPLE_P1.
  - joy2 stays 8'hFF throughout.
- joy_local=6'b111101 with jjoy=8'hFF:
  - joy1 becomes 8'hFD after 3 scans.
  - joy2 is unaffected.
- Pulse jjoy bit 4 low for exactly 2 consecutive P2 samples, then release: joy2 never changes.
- Hold jcoin[0] low for 3 scans, then release:
  - coin[0] goes 0 at scan 3.
  - coin[0] stays 0 for 16 further scan_done pulses, then returns to 1 once the debounced input is 1.
- Assert reset mid-SETTLE_P2 while joy1=8'hFE:
  - All outputs return to reset values immediately.
  - jselect=0 immediately.
  - After release, the first sample occurs SETTLE_CYCLES+1 ce ticks later.
  - Hold ce low for 20 cycles: no state change and no scan_done.
